bank_write_arbiter: RTL



---
 rtl/bank_write_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bank_write_arbiter.sv
// Round-robin write arbiter sharing 8 bank groups among 8 LSU write ports.
// Each bank group has its own rotating priority pointer. Grants are
// combinational (valid/ready), the per-bank write is registered, and a
// saturating counter accumulates stalled requester-cycles.
module bank_write_arbiter #(
  parameter int N_LSU  = 8,
  parameter int N_BG   = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_LSU-1:0]        lsu_w_valid,
  input  logic [3*N_LSU-1:0]      lsu_w_sel,
  input  logic [DATA_W*N_LSU-1:0] lsu_w_data,
  output logic [N_LSU-1:0]        lsu_w_ready,
  output logic [N_BG-1:0]         bg_wen,
  output logic [DATA_W*N_BG-1:0]  bg_wdata,
  input  logic                    stall_clr,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]             rr_ptr_q [N_BG];
  logic [2:0]             rr_ptr_d [N_BG];
  logic [N_BG-1:0]        bg_wen_q, bg_wen_d;
  logic [DATA_W*N_BG-1:0] bg_wdata_q, bg_wdata_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic [N_BG-1:0]        bg_hit;
  logic [2:0]             bg_gnt [N_BG];
  logic [2:0]             scan_idx;
  logic [3:0]             stall_pop;
  logic [CNT_W:0]         stall_pop_ext;
  logic [CNT_W:0]         stall_sum;

  // Per bank group: scan LSUs starting at the pointer and take the first requester.
  always_comb begin
    bg_hit   = '0;
    scan_idx = '0;
    for (int b = 0; b < N_BG; b++) begin
      bg_gnt[b] = '0;
    end
    for (int b = 0; b < N_BG; b++) begin
      for (int k = 0; k < N_LSU; k++) begin
        scan_idx = rr_ptr_q[b] + 3'(k);
        if (!bg_hit[b] && lsu_w_valid[scan_idx] &&
            (lsu_w_sel[3*scan_idx +: 3] == 3'(b))) begin
          bg_hit[b] = 1'b1;
          bg_gnt[b] = scan_idx;
        end
      end
    end
  end

  // Ready back to the winning LSUs; nobody is granted while reset is held.
  always_comb begin
    lsu_w_ready = '0;
    for (int b = 0; b < N_BG; b++) begin
      if (bg_hit[b]) begin
        lsu_w_ready[bg_gnt[b]] = 1'b1;
      end
    end
    if (!rst_n) begin
      lsu_w_ready = '0;
    end
  end

  // Next bank writes and pointer advance past each winner.
  always_comb begin
    bg_wen_d   = '0;
    bg_wdata_d = '0;
    for (int b = 0; b < N_BG; b++) begin
      rr_ptr_d[b] = rr_ptr_q[b];
      if (bg_hit[b]) begin
        bg_wen_d[b]                    = 1'b1;
        bg_wdata_d[DATA_W*b +: DATA_W] = lsu_w_data[DATA_W*bg_gnt[b] +: DATA_W];
        rr_ptr_d[b]                    = bg_gnt[b] + 3'd1;
      end
    end
  end

  // Saturating stall count; clear wins over that cycle's increment.
  always_comb begin
    stall_pop     = '0;
    stall_pop_ext = '0;
    for (int i = 0; i < N_LSU; i++) begin
      stall_pop = stall_pop + {3'b000, (lsu_w_valid[i] & ~lsu_w_ready[i])};
    end
    stall_pop_ext[3:0] = stall_pop;
    stall_sum          = {1'b0, stall_cnt_q} + stall_pop_ext;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (stall_sum > {1'b0, CNT_MAX}) begin
      stall_cnt_d = CNT_MAX;
    end else begin
      stall_cnt_d = stall_sum[CNT_W-1:0];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BG; b++) begin
        rr_ptr_q[b] <= '0;
      end
      bg_wen_q    <= '0;
      bg_wdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int b = 0; b < N_BG; b++) begin
        rr_ptr_q[b] <= rr_ptr_d[b];
      end
      bg_wen_q    <= bg_wen_d;
      bg_wdata_q  <= bg_wdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bg_wen    = bg_wen_q;
  assign bg_wdata  = bg_wdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule
